// File: rtl/rng_pkg.sv
// Shared register map, bit positions and packer state type for the rng_mmio peripheral.
package rng_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic {
    LO,
    HI
  } pack_state_t;

endpackage

// File: rtl/rng_mmio_if.sv
// Simple data-bus slave port: one-cycle access strobe, registered read data with a valid pulse.
interface rng_mmio_if;

  logic        bus_sel;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  modport master (
    output bus_sel, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_sel, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head; a push into a full FIFO is taken when a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // When full with a pop, wr_ptr equals rd_ptr: the head is read out this cycle before being overwritten.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rng_mmio.sv
// Random-number peripheral: decimates the LFSR, packs two 16-bit samples per word and buffers them for bus reads.
module rng_mmio
  import rng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DECIM = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] rand_i,
  rng_mmio_if.slave   mmio
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic          en;
  logic          ovf;
  logic [CW-1:0] decim_cnt;
  logic [15:0]   lo;
  pack_state_t   state;
  pack_state_t   next_state;
  logic          strobe;
  logic          push;
  logic          pop;
  logic          rd;
  logic          wr;
  logic          clr;
  logic [1:0]    reg_idx;
  logic          fifo_full;
  logic          fifo_empty;
  logic [NW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic [31:0]   status_word;
  logic [31:0]   rdata_next;
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          unused_bits;

  assign reg_idx     = mmio.bus_addr[3:2];
  assign rd          = mmio.bus_sel && !mmio.bus_we;
  assign wr          = mmio.bus_sel && mmio.bus_we;
  assign clr         = wr && (reg_idx == REG_CTRL) && mmio.bus_wdata[CTRL_CLR];
  assign pop         = rd && (reg_idx == REG_DATA) && !fifo_empty;
  assign strobe      = en && (decim_cnt == CW'(DECIM - 1));
  assign unused_bits = ^{mmio.bus_addr[1:0], mmio.bus_wdata[31:3]};

  always_ff @(posedge clk) begin
    if (!reset_n || clr) decim_cnt <= '0;
    else if (en)         decim_cnt <= strobe ? '0 : decim_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) state <= LO;
    else                 state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    case (state)
      LO: if (strobe) next_state = HI;
      HI: if (strobe) begin
        next_state = LO;
        push       = 1'b1;
      end
    endcase
  end

  // The low half survives en being dropped so a paused word completes with its original sample.
  always_ff @(posedge clk) begin
    if (!reset_n)                   lo <= '0;
    else if (state == LO && strobe) lo <= rand_i;
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wdata   ({rand_i, lo}),
    .rdata   (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // An overflow in the same cycle as a W1C write keeps ovf set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (wr && reg_idx == REG_CTRL) en <= mmio.bus_wdata[CTRL_EN];
      if (clr)                               ovf <= 1'b0;
      else if (push && fifo_full && !pop)    ovf <= 1'b1;
      else if (wr && reg_idx == REG_STATUS && mmio.bus_wdata[STAT_OVF]) ovf <= 1'b0;
    end
  end

  always_comb begin
    status_word                             = '0;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_OVF]                   = ovf;
    status_word[STAT_COUNT_LSB +: 8]        = 8'(fifo_count);
  end

  always_comb begin
    rdata_next = '0;
    case (reg_idx)
      REG_DATA:   rdata_next = fifo_empty ? 32'h0 : fifo_head;
      REG_STATUS: rdata_next = status_word;
      REG_CTRL:   rdata_next = {31'h0, en};
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rdata_next;
    end
  end

  assign mmio.bus_rdata  = rdata_q;
  assign mmio.bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_rng_mmio.sv
// Self-checking bench for rng_mmio: register vector table plus timed sequences against a read scoreboard.
module tb_rng_mmio;
  import rng_pkg::*;

  localparam int DEPTH = 4;
  localparam int D     = 3;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    bit          we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rand_i;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  vec_t        vecs[$];

  rng_mmio_if bus_if ();

  rng_mmio #(
    .DEPTH (DEPTH),
    .DECIM (D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rand_i  (rand_i),
    .mmio    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int c);
    int v;
    v = c * 40503 + 4660;
    return v[15:0];
  endfunction

  assign rand_i = pat(cyc);

  // Word n after en is raised at cycle t0 with counter and packer at their start state.
  function automatic logic [31:0] word(input int t0, input int n);
    return {pat(t0 + (2 * n + 2) * D), pat(t0 + (2 * n + 1) * D)};
  endfunction

  function automatic logic [31:0] status(input int cnt, input bit ovf, input bit full, input bit empty);
    return {16'h0, 8'(cnt), 5'h0, ovf, full, empty};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_if.bus_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid=1 expected no read pending (rdata 0x%08h)",
                 bus_if.bus_rdata);
      end else begin
        e = sb.pop_front();
        check_output(e.name, bus_if.bus_rdata, e.exp);
      end
    end
  end

  task automatic apply_stimulus(input string name, input bit we, input logic [3:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp);
    bus_if.bus_sel   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    if (!we) sb.push_back('{name, exp});
    @(posedge clk); #1;
    bus_if.bus_sel   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
  endtask

  task automatic do_read(input string name, input logic [3:0] addr, input logic [31:0] exp);
    apply_stimulus(name, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    apply_stimulus("write", 1'b1, addr, data, 32'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $display("[TB] FAIL schedule: at cycle %0d required cycle %0d", cyc, c);
    end
    while (cyc < c) tick(1);
  endtask

  task automatic drain(input string name);
    tick(2);
    check_output(name, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, t1, t2, t3;

    bus_if.bus_sel   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;

    vecs.push_back('{"empty_data",     1'b0, 4'h0, 32'h0,        32'h0000_0000});
    vecs.push_back('{"reset_status",   1'b0, 4'h4, 32'h0,        32'h0000_0001});
    vecs.push_back('{"reset_ctrl",     1'b0, 4'h8, 32'h0,        32'h0000_0000});
    vecs.push_back('{"reserved_read",  1'b0, 4'hC, 32'h0,        32'h0000_0000});
    vecs.push_back('{"reserved_write", 1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{"ctrl_after_rsv", 1'b0, 4'h8, 32'h0,        32'h0000_0000});
    vecs.push_back('{"status_after_rsv", 1'b0, 4'h4, 32'h0,      32'h0000_0001});
    vecs.push_back('{"w1c_idle",       1'b1, 4'h4, 32'h4,        32'h0});
    vecs.push_back('{"status_w1c_idle", 1'b0, 4'h4, 32'h0,       32'h0000_0001});
    vecs.push_back('{"en_on",          1'b1, 4'h8, 32'h1,        32'h0});
    vecs.push_back('{"ctrl_en",        1'b0, 4'h8, 32'h0,        32'h0000_0001});
    vecs.push_back('{"en_off",         1'b1, 4'h8, 32'h0,        32'h0});
    vecs.push_back('{"ctrl_low_bits",  1'b0, 4'h9, 32'h0,        32'h0000_0000});
    vecs.push_back('{"clr",            1'b1, 4'h8, 32'h2,        32'h0});
    vecs.push_back('{"status_low_bits", 1'b0, 4'h5, 32'h0,       32'h0000_0001});
    vecs.push_back('{"ctrl_after_clr", 1'b0, 4'h8, 32'h0,        32'h0000_0000});

    tick(3);
    check_output("reset_rvalid", 32'(bus_if.bus_rvalid), 32'h0);
    check_output("reset_rdata", bus_if.bus_rdata, 32'h0);
    reset_n = 1'b1;

    $display("[TB] register table");
    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    drain("table_drain");

    $display("[TB] basic pack");
    t0 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t0 + 2 * D);
    do_read("pack_status_pre", 4'h4, status(0, 0, 0, 1));
    do_read("pack_status_post", 4'h4, status(1, 0, 0, 0));
    do_write(4'h8, 32'h0);
    do_read("pack_data", 4'h0, word(t0, 0));
    do_read("pack_status_empty", 4'h4, status(0, 0, 0, 1));
    do_write(4'h8, 32'h2);
    drain("pack_drain");

    $display("[TB] overflow");
    t0 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t0 + 10 * D);
    do_write(4'h4, 32'h4);
    do_write(4'h8, 32'h0);
    do_read("ovf_status", 4'h4, status(4, 1, 1, 0));
    do_write(4'h4, 32'h3);
    do_read("ovf_keep_no_bit2", 4'h4, status(4, 1, 1, 0));
    do_write(4'h4, 32'h4);
    do_read("ovf_w1c", 4'h4, status(4, 0, 1, 0));
    for (int i = 0; i < DEPTH; i++) do_read($sformatf("ovf_data%0d", i), 4'h0, word(t0, i));
    do_read("ovf_data_empty", 4'h0, 32'h0);
    do_read("ovf_status_end", 4'h4, status(0, 0, 0, 1));

    t0 = cyc;
    do_write(4'h8, 32'h3);
    wait_until(t0 + 10 * D + 1);
    do_read("clr_en_ovf_status", 4'h4, status(4, 1, 1, 0));
    do_write(4'h8, 32'h2);
    do_read("clr_clears_ovf", 4'h4, status(0, 0, 0, 1));
    drain("ovf_drain");

    $display("[TB] push/pop collision");
    t0 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t0 + 10 * D);
    do_read("coll_data0", 4'h0, word(t0, 0));
    do_write(4'h8, 32'h0);
    do_read("coll_status", 4'h4, status(4, 0, 1, 0));
    for (int i = 1; i <= DEPTH; i++) do_read($sformatf("coll_data%0d", i), 4'h0, word(t0, i));
    do_read("coll_status_end", 4'h4, status(0, 0, 0, 1));
    do_write(4'h8, 32'h2);
    drain("coll_drain");

    $display("[TB] pause and clear");
    t0 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t0 + D + 1);
    do_write(4'h8, 32'h0);
    wait_until(t0 + D + 12);
    do_read("pause_status", 4'h4, status(0, 0, 0, 1));
    wait_until(t0 + D + 22);
    t1 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t1 + D);
    do_write(4'h8, 32'h0);
    do_read("resume_status", 4'h4, status(1, 0, 0, 0));
    do_read("resume_data", 4'h0, {pat(t1 + D - 1), pat(t0 + D)});
    do_read("resume_status_end", 4'h4, status(0, 0, 0, 1));

    t2 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t2 + 2 * D);
    do_read("preclr_status", 4'h4, status(1, 0, 0, 0));
    wait_until(t2 + 3 * D);
    do_write(4'h8, 32'h2);
    do_read("clr_status", 4'h4, status(0, 0, 0, 1));
    do_read("clr_ctrl", 4'h8, 32'h0);
    tick(3 * D);
    do_read("clr_idle_status", 4'h4, status(0, 0, 0, 1));
    t3 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t3 + 2 * D + 1);
    do_read("clr_restart_data", 4'h0, word(t3, 0));
    do_write(4'h8, 32'h2);
    drain("pause_drain");

    $display("[TB] reset mid-operation");
    t0 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t0 + 5 * D + 1);
    bus_if.bus_sel  = 1'b1;
    bus_if.bus_we   = 1'b0;
    bus_if.bus_addr = 4'h0;
    reset_n         = 1'b0;
    @(posedge clk); #1;
    bus_if.bus_sel  = 1'b0;
    reset_n         = 1'b1;
    check_output("rst_rvalid", 32'(bus_if.bus_rvalid), 32'h0);
    check_output("rst_rdata", bus_if.bus_rdata, 32'h0);
    do_read("rst_status", 4'h4, status(0, 0, 0, 1));
    do_read("rst_ctrl", 4'h8, 32'h0);
    tick(3 * D);
    do_read("rst_idle_status", 4'h4, status(0, 0, 0, 1));
    t1 = cyc;
    do_write(4'h8, 32'h1);
    wait_until(t1 + 2 * D + 1);
    do_read("rst_restart_data", 4'h0, word(t1, 0));
    do_read("rst_restart_status", 4'h4, status(0, 0, 0, 1));
    do_write(4'h8, 32'h2);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
